// File: rtl/instruction_fetch_if.sv
// Fetch-unit bus bundle: instruction-memory handshake, decode handshake,
// branch redirect inputs and status outputs.
interface instruction_fetch_if #(
  parameter int XLEN = 64
);
  logic            MemReq;
  logic [XLEN-1:0] MemAddr;
  logic            MemAck;
  logic [31:0]     MemRData;
  logic            InstrValid;
  logic [31:0]     Instr;
  logic [XLEN-1:0] InstrPC;
  logic            DecReady;
  logic            BranchTaken;
  logic [XLEN-1:0] BranchTarget;
  logic            MisalignErr;
  logic [XLEN-1:0] FetchCount;

  modport master (
    output MemReq, MemAddr, InstrValid, Instr, InstrPC, MisalignErr, FetchCount,
    input  MemAck, MemRData, DecReady, BranchTaken, BranchTarget
  );

  modport slave (
    input  MemReq, MemAddr, InstrValid, Instr, InstrPC, MisalignErr, FetchCount,
    output MemAck, MemRData, DecReady, BranchTaken, BranchTarget
  );
endinterface

// File: rtl/instruction_fetch.sv
// Single-issue instruction fetch: requests a word at PC, hands it to decode,
// advances by 4, and follows (or halts on misaligned) branch redirects.
module instruction_fetch #(
  parameter int              XLEN     = 64,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic                Clock,
  input  logic                ResetN,
  instruction_fetch_if.master bus
);

  typedef enum logic [1:0] {
    FETCH = 2'd0,
    VALID = 2'd1,
    HALT  = 2'd2
  } state_t;

  state_t          r_state;
  logic            r_memReq;
  logic            r_instrValid;
  logic            r_misalignErr;
  logic [XLEN-1:0] r_pc;
  logic [XLEN-1:0] r_instrPC;
  logic [XLEN-1:0] r_fetchCount;
  logic [31:0]     r_instr;

  logic            w_redirect;
  logic            w_misaligned;

  assign w_redirect   = bus.BranchTaken && (bus.BranchTarget[1:0] == 2'b00);
  assign w_misaligned = bus.BranchTaken && (bus.BranchTarget[1:0] != 2'b00);

  assign bus.MemReq      = r_memReq;
  assign bus.MemAddr     = r_pc;
  assign bus.InstrValid  = r_instrValid;
  assign bus.Instr       = r_instr;
  assign bus.InstrPC     = r_instrPC;
  assign bus.MisalignErr = r_misalignErr;
  assign bus.FetchCount  = r_fetchCount;

  // Redirects outrank both MemAck and DecReady, so a coinciding memory word or
  // decode accept is simply dropped.
  always_ff @(posedge Clock or negedge ResetN) begin
    if (!ResetN) begin
      r_state       <= FETCH;
      r_memReq      <= 1'b1;
      r_instrValid  <= 1'b0;
      r_misalignErr <= 1'b0;
      r_pc          <= RESET_PC;
      r_instrPC     <= '0;
      r_fetchCount  <= '0;
      r_instr       <= '0;
    end else begin
      case (r_state)
        FETCH: begin
          if (w_misaligned) begin
            r_misalignErr <= 1'b1;
            r_memReq      <= 1'b0;
            r_state       <= HALT;
          end else if (w_redirect) begin
            r_pc <= bus.BranchTarget;
          end else if (bus.MemAck) begin
            r_instr      <= bus.MemRData;
            r_instrPC    <= r_pc;
            r_memReq     <= 1'b0;
            r_instrValid <= 1'b1;
            r_state      <= VALID;
          end
        end
        VALID: begin
          if (w_misaligned) begin
            r_misalignErr <= 1'b1;
            r_instrValid  <= 1'b0;
            r_state       <= HALT;
          end else if (w_redirect) begin
            r_pc         <= bus.BranchTarget;
            r_memReq     <= 1'b1;
            r_instrValid <= 1'b0;
            r_state      <= FETCH;
          end else if (bus.DecReady) begin
            r_pc         <= r_pc + XLEN'(4);
            r_fetchCount <= r_fetchCount + XLEN'(1);
            r_memReq     <= 1'b1;
            r_instrValid <= 1'b0;
            r_state      <= FETCH;
          end
        end
        HALT: begin
          r_state <= HALT;
        end
        default: begin
          r_state <= HALT;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_instruction_fetch.sv
// Scoreboard bench for instruction_fetch: a tagged-word memory model feeds the
// DUT and expected (Instr, InstrPC) pairs are queued at ack, checked at accept.
module tb_instruction_fetch;

  logic Clock;
  logic ResetN;

  instruction_fetch_if #(.XLEN(64)) bus ();
  instruction_fetch_if #(.XLEN(64)) bus2 ();

  instruction_fetch #(.XLEN(64), .RESET_PC(64'h0)) u_dut (
    .Clock  (Clock),
    .ResetN (ResetN),
    .bus    (bus.master)
  );

  instruction_fetch #(.XLEN(64), .RESET_PC(64'hFFFF_FFFF_FFFF_FFFC)) u_dutWrap (
    .Clock  (Clock),
    .ResetN (ResetN),
    .bus    (bus2.master)
  );

  typedef struct {
    logic [31:0] instr;
    logic [63:0] pc;
  } exp_t;

  exp_t        sbq[$];
  int          errors = 0;
  int          checks = 0;
  logic [63:0] expPc;
  logic [63:0] expCount;

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  function automatic logic [31:0] tag(input logic [63:0] addr);
    return addr[31:0] ^ 32'hA5A5_0000;
  endfunction

  task automatic step();
    @(posedge Clock);
    #1;
  endtask

  task automatic doReset();
    bus.MemAck = 1'b0; bus.MemRData = '0; bus.DecReady = 1'b0;
    bus.BranchTaken = 1'b0; bus.BranchTarget = '0;
    bus2.MemAck = 1'b0; bus2.MemRData = '0; bus2.DecReady = 1'b0;
    bus2.BranchTaken = 1'b0; bus2.BranchTarget = '0;
    ResetN = 1'b0;
    #2;
    ResetN = 1'b1;
    expPc = 64'h0;
    expCount = 64'h0;
    sbq.delete();
  endtask

  task automatic test_reset();
    ResetN = 1'b0;
    step();
    step();
    checks++;
    if (bus.MemReq !== 1'b1 || bus.InstrValid !== 1'b0 || bus.MisalignErr !== 1'b0) begin
      errors++;
      $display("[TB] FAIL reset_ctrl got req=%b vld=%b err=%b exp 1 0 0",
               bus.MemReq, bus.InstrValid, bus.MisalignErr);
    end
    checks++;
    if (bus.MemAddr !== 64'h0 || bus.FetchCount !== 64'h0) begin
      errors++;
      $display("[TB] FAIL reset_regs got addr=%h cnt=%h exp 0 0", bus.MemAddr, bus.FetchCount);
    end
    checks++;
    if (bus.Instr !== 32'h0 || bus.InstrPC !== 64'h0) begin
      errors++;
      $display("[TB] FAIL reset_instr got instr=%h pc=%h exp 0 0", bus.Instr, bus.InstrPC);
    end
    doReset();
  endtask

  task automatic test_stream();
    int   st;
    exp_t e;
    st = 0;
    doReset();
    bus.MemAck = 1'b1;
    bus.DecReady = 1'b1;
    for (int i = 0; i < 16; i++) begin
      bus.MemRData = tag(bus.MemAddr);
      checks++;
      if (bus.FetchCount !== expCount) begin
        errors++;
        $display("[TB] FAIL stream_count got=%h exp=%h", bus.FetchCount, expCount);
      end
      if (st == 0) begin
        checks++;
        if (bus.MemReq !== 1'b1 || bus.InstrValid !== 1'b0 || bus.MemAddr !== expPc) begin
          errors++;
          $display("[TB] FAIL stream_fetch got req=%b vld=%b addr=%h exp 1 0 %h",
                   bus.MemReq, bus.InstrValid, bus.MemAddr, expPc);
        end
        sbq.push_back('{tag(expPc), expPc});
        st = 1;
      end else begin
        checks++;
        if (sbq.size() == 0) begin
          errors++;
          $display("[TB] FAIL stream_queue got empty scoreboard exp one entry");
        end else begin
          e = sbq.pop_front();
          if (bus.InstrValid !== 1'b1 || bus.Instr !== e.instr || bus.InstrPC !== e.pc) begin
            errors++;
            $display("[TB] FAIL stream_instr got vld=%b instr=%h pc=%h exp 1 %h %h",
                     bus.InstrValid, bus.Instr, bus.InstrPC, e.instr, e.pc);
          end
        end
        expPc = expPc + 64'd4;
        expCount = expCount + 64'd1;
        st = 0;
      end
      step();
    end
    checks++;
    if (bus.FetchCount !== 64'd8) begin
      errors++;
      $display("[TB] FAIL stream_total got=%h exp=8", bus.FetchCount);
    end
    bus.MemAck = 1'b0;
    bus.DecReady = 1'b0;
  endtask

  task automatic test_stall();
    exp_t e;
    for (int rep = 0; rep < 2; rep++) begin
      for (int k = 0; k < 3; k++) begin
        bus.MemAck = 1'b0;
        checks++;
        if (bus.MemReq !== 1'b1 || bus.InstrValid !== 1'b0 || bus.MemAddr !== expPc) begin
          errors++;
          $display("[TB] FAIL stall_fetch got req=%b vld=%b addr=%h exp 1 0 %h",
                   bus.MemReq, bus.InstrValid, bus.MemAddr, expPc);
        end
        step();
      end
      bus.MemAck = 1'b1;
      bus.MemRData = tag(bus.MemAddr);
      sbq.push_back('{tag(expPc), expPc});
      step();
      bus.MemAck = 1'b0;
      bus.MemRData = 32'hDEAD_BEEF;
      for (int k = 0; k < 3; k++) begin
        bus.DecReady = (k == 2);
        checks++;
        if (sbq.size() == 0) begin
          errors++;
          $display("[TB] FAIL stall_queue got empty scoreboard exp one entry");
        end else if (bus.InstrValid !== 1'b1 || bus.Instr !== sbq[0].instr ||
                     bus.InstrPC !== sbq[0].pc || bus.FetchCount !== expCount ||
                     bus.MemReq !== 1'b0) begin
          errors++;
          $display("[TB] FAIL stall_hold got vld=%b instr=%h pc=%h cnt=%h exp 1 %h %h %h",
                   bus.InstrValid, bus.Instr, bus.InstrPC, bus.FetchCount,
                   sbq[0].instr, sbq[0].pc, expCount);
        end
        step();
      end
      if (sbq.size() != 0) e = sbq.pop_front();
      expPc = expPc + 64'd4;
      expCount = expCount + 64'd1;
      bus.DecReady = 1'b0;
    end
    checks++;
    if (bus.FetchCount !== expCount || bus.MemAddr !== expPc || bus.MemReq !== 1'b1) begin
      errors++;
      $display("[TB] FAIL stall_after got cnt=%h addr=%h req=%b exp %h %h 1",
               bus.FetchCount, bus.MemAddr, bus.MemReq, expCount, expPc);
    end
  endtask

  task automatic test_branch();
    doReset();
    bus.MemAck = 1'b1;
    bus.DecReady = 1'b1;
    for (int i = 0; i < 4; i++) begin
      bus.MemRData = tag(bus.MemAddr);
      step();
    end
    checks++;
    if (bus.MemAddr !== 64'h8 || bus.FetchCount !== 64'd2 || bus.MemReq !== 1'b1) begin
      errors++;
      $display("[TB] FAIL branch_setup got addr=%h cnt=%h req=%b exp 8 2 1",
               bus.MemAddr, bus.FetchCount, bus.MemReq);
    end
    bus.BranchTaken = 1'b1;
    bus.BranchTarget = 64'h100;
    bus.MemRData = 32'hBAD0_0008;
    step();
    bus.BranchTaken = 1'b0;
    checks++;
    if (bus.MemReq !== 1'b1 || bus.InstrValid !== 1'b0 || bus.MemAddr !== 64'h100) begin
      errors++;
      $display("[TB] FAIL branch_fetch got req=%b vld=%b addr=%h exp 1 0 100",
               bus.MemReq, bus.InstrValid, bus.MemAddr);
    end
    checks++;
    if (bus.Instr !== tag(64'h4) || bus.InstrPC !== 64'h4 || bus.FetchCount !== 64'd2) begin
      errors++;
      $display("[TB] FAIL branch_discard got instr=%h pc=%h cnt=%h exp %h 4 2",
               bus.Instr, bus.InstrPC, bus.FetchCount, tag(64'h4));
    end
    bus.MemRData = tag(bus.MemAddr);
    bus.DecReady = 1'b0;
    step();
    bus.MemAck = 1'b0;
    bus.DecReady = 1'b1;
    bus.BranchTaken = 1'b1;
    bus.BranchTarget = 64'h200;
    step();
    bus.BranchTaken = 1'b0;
    bus.DecReady = 1'b0;
    checks++;
    if (bus.FetchCount !== 64'd2 || bus.MemAddr !== 64'h200 || bus.InstrValid !== 1'b0 ||
        bus.Instr !== tag(64'h100) || bus.InstrPC !== 64'h100) begin
      errors++;
      $display("[TB] FAIL branch_squash got cnt=%h addr=%h vld=%b instr=%h pc=%h exp 2 200 0 %h 100",
               bus.FetchCount, bus.MemAddr, bus.InstrValid, bus.Instr, bus.InstrPC,
               tag(64'h100));
    end
  endtask

  task automatic test_misalign();
    bus.BranchTaken = 1'b1;
    bus.BranchTarget = 64'h102;
    bus.MemAck = 1'b1;
    step();
    checks++;
    if (bus.MisalignErr !== 1'b1 || bus.MemReq !== 1'b0 || bus.InstrValid !== 1'b0 ||
        bus.MemAddr !== 64'h200) begin
      errors++;
      $display("[TB] FAIL misalign_enter got err=%b req=%b vld=%b addr=%h exp 1 0 0 200",
               bus.MisalignErr, bus.MemReq, bus.InstrValid, bus.MemAddr);
    end
    bus.BranchTarget = 64'h300;
    bus.DecReady = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      checks++;
      if (bus.MisalignErr !== 1'b1 || bus.MemReq !== 1'b0 || bus.InstrValid !== 1'b0 ||
          bus.MemAddr !== 64'h200 || bus.FetchCount !== 64'd2) begin
        errors++;
        $display("[TB] FAIL misalign_halt got err=%b req=%b vld=%b addr=%h cnt=%h exp 1 0 0 200 2",
                 bus.MisalignErr, bus.MemReq, bus.InstrValid, bus.MemAddr, bus.FetchCount);
      end
    end
    doReset();
    checks++;
    if (bus.MisalignErr !== 1'b0 || bus.MemReq !== 1'b1 || bus.MemAddr !== 64'h0) begin
      errors++;
      $display("[TB] FAIL misalign_clear got err=%b req=%b addr=%h exp 0 1 0",
               bus.MisalignErr, bus.MemReq, bus.MemAddr);
    end
  endtask

  task automatic test_wrap();
    exp_t e;
    doReset();
    checks++;
    if (bus2.MemAddr !== 64'hFFFF_FFFF_FFFF_FFFC || bus2.MemReq !== 1'b1) begin
      errors++;
      $display("[TB] FAIL wrap_reset got addr=%h req=%b exp fffffffffffffffc 1",
               bus2.MemAddr, bus2.MemReq);
    end
    bus2.MemAck = 1'b1;
    bus2.MemRData = tag(bus2.MemAddr);
    sbq.push_back('{tag(64'hFFFF_FFFF_FFFF_FFFC), 64'hFFFF_FFFF_FFFF_FFFC});
    step();
    bus2.MemAck = 1'b0;
    bus2.DecReady = 1'b1;
    checks++;
    if (sbq.size() == 0) begin
      errors++;
      $display("[TB] FAIL wrap_queue got empty scoreboard exp one entry");
    end else begin
      e = sbq.pop_front();
      if (bus2.InstrValid !== 1'b1 || bus2.Instr !== e.instr || bus2.InstrPC !== e.pc) begin
        errors++;
        $display("[TB] FAIL wrap_instr got vld=%b instr=%h pc=%h exp 1 %h %h",
                 bus2.InstrValid, bus2.Instr, bus2.InstrPC, e.instr, e.pc);
      end
    end
    step();
    bus2.DecReady = 1'b0;
    checks++;
    if (bus2.MemAddr !== 64'h0 || bus2.FetchCount !== 64'd1 || bus2.MisalignErr !== 1'b0 ||
        bus2.MemReq !== 1'b1) begin
      errors++;
      $display("[TB] FAIL wrap_next got addr=%h cnt=%h err=%b req=%b exp 0 1 0 1",
               bus2.MemAddr, bus2.FetchCount, bus2.MisalignErr, bus2.MemReq);
    end
  endtask

  task automatic test_async_reset();
    doReset();
    bus.MemAck = 1'b1;
    bus.DecReady = 1'b1;
    bus.MemRData = tag(bus.MemAddr);
    step();
    step();
    bus.DecReady = 1'b0;
    bus.MemRData = tag(bus.MemAddr);
    step();
    checks++;
    if (bus.InstrValid !== 1'b1 || bus.FetchCount !== 64'd1 || bus.InstrPC !== 64'h4) begin
      errors++;
      $display("[TB] FAIL async_setup got vld=%b cnt=%h pc=%h exp 1 1 4",
               bus.InstrValid, bus.FetchCount, bus.InstrPC);
    end
    #3;
    ResetN = 1'b0;
    #1;
    checks++;
    if (bus.InstrValid !== 1'b0 || bus.MemReq !== 1'b1 || bus.MemAddr !== 64'h0 ||
        bus.FetchCount !== 64'h0 || bus.Instr !== 32'h0) begin
      errors++;
      $display("[TB] FAIL async_reset got vld=%b req=%b addr=%h cnt=%h instr=%h exp 0 1 0 0 0",
               bus.InstrValid, bus.MemReq, bus.MemAddr, bus.FetchCount, bus.Instr);
    end
    #1;
    ResetN = 1'b1;
    bus.MemRData = tag(64'h0);
    step();
    bus.MemAck = 1'b0;
    checks++;
    if (bus.InstrValid !== 1'b1 || bus.InstrPC !== 64'h0 || bus.Instr !== tag(64'h0)) begin
      errors++;
      $display("[TB] FAIL async_release got vld=%b pc=%h instr=%h exp 1 0 %h",
               bus.InstrValid, bus.InstrPC, bus.Instr, tag(64'h0));
    end
  endtask

  initial begin
    ResetN = 1'b0;
    bus.MemAck = 1'b0; bus.MemRData = '0; bus.DecReady = 1'b0;
    bus.BranchTaken = 1'b0; bus.BranchTarget = '0;
    bus2.MemAck = 1'b0; bus2.MemRData = '0; bus2.DecReady = 1'b0;
    bus2.BranchTaken = 1'b0; bus2.BranchTarget = '0;
    expPc = 64'h0;
    expCount = 64'h0;
    test_reset();
    test_stream();
    test_stall();
    test_branch();
    test_misalign();
    test_wrap();
    test_async_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
